// File: rtl/rf_dump.sv
// rf_dump -- sequential reader for a 2**pw x dw register file.
//
// On a start pulse the block walks every register index from 0 to 2**pw-1.
// It drives the index on the combinational read port of the register file,
// captures the returned word into an output register and offers it on a
// valid/ready stream tagged with its index.  It gives a synthesizable
// path from register-file contents to a debug UART, trace buffer or monitor.
//
// Ports:
//   clk        in   1    single clock, all state changes on posedge
//   reset      in   1    synchronous, active-high reset
//   start      in   1    dump request, only honoured while idle
//   rd_addr    out  pw   read address to the register file read port
//   rd_data    in   dw   combinational read data for rd_addr
//   out_valid  out  1    out_data / out_addr hold a word
//   out_ready  in   1    consumer accepts the word together with out_valid
//   out_data   out  dw   captured register value
//   out_addr   out  pw   register index of out_data
//   out_last   out  1    marks the word for index 2**pw-1
//   busy       out  1    a dump is in progress
//   done       out  1    one-cycle pulse after the last word is accepted
module rf_dump #(
   parameter int pw = 4,
   parameter int dw = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   output logic [pw-1:0] rd_addr,
   input  logic [dw-1:0] rd_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [dw-1:0] out_data,
   output logic [pw-1:0] out_addr,
   output logic          out_last,
   output logic          busy,
   output logic          done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SEND = 2'd2
   } state_t;

   localparam logic [pw-1:0] LAST_IDX = {pw{1'b1}};
   localparam logic [pw-1:0] IDX_ONE  = {{(pw-1){1'b0}}, 1'b1};

   state_t          state_q;
   logic [pw-1:0]   idx_q;
   logic            out_valid_q;
   logic [dw-1:0]   out_data_q;
   logic [pw-1:0]   out_addr_q;
   logic            out_last_q;
   logic            busy_q;
   logic            done_q;

   // Dump sequencer: state, index counter and all registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         // Any word in flight is dropped and no done pulse is produced.
         state_q     <= IDLE;
         idx_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_addr_q  <= '0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         // done is a single-cycle pulse unless the SEND branch raises it.
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= LOAD;
               end else begin
                  idx_q   <= '0;
                  state_q <= IDLE;
               end
            end
            LOAD: begin
               // Read data is sampled here, so a write to this register
               // landing before this cycle is reflected in the dump.
               out_data_q  <= rd_data;
               out_addr_q  <= idx_q;
               out_last_q  <= (idx_q == LAST_IDX);
               out_valid_q <= 1'b1;
               state_q     <= SEND;
            end
            SEND: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  if (out_last_q) begin
                     // Terminate on the last index; idx never wraps.
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     idx_q   <= '0;
                     state_q <= IDLE;
                  end else begin
                     idx_q   <= idx_q + IDX_ONE;
                     state_q <= LOAD;
                  end
               end else begin
                  // Backpressure: every output holds its value.
                  state_q <= SEND;
               end
            end
            default: begin
               state_q     <= IDLE;
               idx_q       <= '0;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign rd_addr   = idx_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_addr  = out_addr_q;
   assign out_last  = out_last_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_rf_dump.sv
module tb_rf_dump;

   logic       clk;
   logic       reset;
   logic       start;
   logic [3:0] rd_addr;
   logic [7:0] rd_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [3:0] out_addr;
   logic       out_last;
   logic       busy;
   logic       done;

   logic [7:0] mem     [16];
   logic [7:0] exp_mem [16];

   typedef struct {
      logic [3:0] addr;
      logic [7:0] data;
      logic       last;
      int         cyc;
   } word_t;

   word_t sb[$];
   int    dq[$];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic       prev_hold = 1'b0;
   logic [7:0] prev_data;
   logic [3:0] prev_addr;
   logic       prev_last;

   rf_dump #(.pw(4), .dw(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_addr  (out_addr),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done)
   );

   // Register-file model with a combinational read port.
   assign rd_data = mem[rd_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, req, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int n);
      while (cyc < n) tick();
   endtask

   // Queue the expected words of a dump started at edge e; words at or
   // after stall_word are delayed by stall_len cycles.
   task automatic push_dump(input int e, input int n_words,
                            input int stall_word, input int stall_len);
      word_t w;
      for (int k = 0; k < n_words; k++) begin
         w.addr = 4'(k);
         w.data = exp_mem[k];
         w.last = (k == 15);
         w.cyc  = e + 1 + 2 * k + ((k >= stall_word) ? stall_len : 0);
         sb.push_back(w);
      end
      if (n_words == 16) dq.push_back(e + 32 + stall_len);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Monitor: checks every handshake and done pulse against the queues.
   always @(negedge clk) begin
      if (reset) begin
         prev_hold = 1'b0;
      end else begin
         if (out_valid && done) chk("valid_with_done", 1, 0);
         if (prev_hold) begin
            chk("hold_data", out_data, prev_data);
            chk("hold_addr", out_addr, prev_addr);
            chk("hold_last", out_last, prev_last);
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_word", 1, 0);
            end else begin
               word_t w;
               w = sb.pop_front();
               chk("word_addr", out_addr, w.addr);
               chk("word_data", out_data, w.data);
               chk("word_last", out_last, w.last);
               chk("word_cycle", cyc, w.cyc);
            end
         end
         if (done) begin
            if (dq.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               chk("done_cycle", cyc, dq.pop_front());
            end
         end
         prev_hold = out_valid && !out_ready;
         prev_data = out_data;
         prev_addr = out_addr;
         prev_last = out_last;
      end
   end

   initial begin
      int e;
      int e2;
      reset     = 1'b1;
      start     = 1'b0;
      out_ready = 1'b0;
      for (int i = 0; i < 16; i++) mem[i] = 8'($urandom_range(0, 255));

      // Reset with random inputs.
      for (int i = 0; i < 2; i++) begin
         start     = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         tick();
      end
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_addr", out_addr, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rd_addr", rd_addr, 0);
      reset     = 1'b0;
      start     = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) mem[i] = 8'(3 * i + 1);
      tick();
      chk("idle_busy", busy, 0);

      // Full dump without backpressure.
      e = cyc + 1;
      exp_mem = mem;
      push_dump(e, 16, 16, 0);
      pulse_start();
      chk("busy_after_start", busy, 1);
      wait_until(e + 31);
      chk("busy_before_end", busy, 1);
      wait_until(e + 32);
      chk("busy_fall", busy, 0);
      chk("done_high", done, 1);
      wait_until(e + 34);
      chk("done_one_cycle", done, 0);

      // Backpressure on word 3 for five cycles.
      e = cyc + 1;
      exp_mem = mem;
      push_dump(e, 16, 3, 5);
      pulse_start();
      wait_until(e + 7);
      chk("bp_addr", out_addr, 3);
      chk("bp_data", out_data, 10);
      out_ready = 1'b0;
      repeat (5) tick();
      chk("bp_addr_end", out_addr, 3);
      chk("bp_data_end", out_data, 10);
      chk("bp_valid_end", out_valid, 1);
      out_ready = 1'b1;
      wait_until(e + 40);

      // start while busy is ignored; start in the done cycle restarts.
      e = cyc + 1;
      exp_mem = mem;
      push_dump(e, 16, 16, 0);
      pulse_start();
      wait_until(e + 13);
      chk("busy_word6_addr", out_addr, 6);
      pulse_start();
      wait_until(e + 32);
      chk("done_cycle_start", done, 1);
      e2 = e + 33;
      push_dump(e2, 16, 16, 0);
      pulse_start();
      wait_until(e2 + 34);

      // Concurrent writes during word 4.
      e = cyc + 1;
      exp_mem = mem;
      exp_mem[9] = 8'hAA;
      push_dump(e, 16, 16, 0);
      pulse_start();
      wait_until(e + 9);
      chk("cw_word4_addr", out_addr, 4);
      mem[9] = 8'hAA;
      mem[2] = 8'h55;
      wait_until(e + 34);
      mem[9] = 8'd28;
      mem[2] = 8'd7;

      // Reset while word 7 is valid.
      e = cyc + 1;
      exp_mem = mem;
      push_dump(e, 7, 16, 0);
      pulse_start();
      wait_until(e + 15);
      chk("mid_addr", out_addr, 7);
      chk("mid_valid", out_valid, 1);
      reset     = 1'b1;
      out_ready = 1'b0;
      tick();
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_rd_addr", rd_addr, 0);
      reset     = 1'b0;
      out_ready = 1'b1;
      repeat (4) tick();
      chk("mid_no_done", done, 0);

      // Fresh dump after the reset starts from index 0.
      e = cyc + 1;
      exp_mem = mem;
      push_dump(e, 16, 16, 0);
      pulse_start();
      wait_until(e + 34);

      chk("words_left", sb.size(), 0);
      chk("dones_left", dq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
